// File: rtl/cpu_pkg.sv
// Shared CPU-core definitions: default widths, reset vector and fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_INST_W   = 32;
    localparam int unsigned INST_BYTES   = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: code-memory req/ack, decode valid/ready and branch redirect.
interface fetch_sequencer_if
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INST_W = DEF_INST_W
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc,
        input  mem_ack, mem_rdata, inst_ready, br_taken, br_target
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc,
        output mem_ack, mem_rdata, inst_ready, br_taken, br_target
    );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches one word at a time from code
// memory, holds it for decode and redirects on taken branches.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                     clk,
    input  logic                     nreset,
    fetch_sequencer_if.master        bus,
    output logic [7:0]               fetch_count
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [1:0]  ST_IDLE = 2'(IDLE);
    localparam logic [1:0]  ST_REQ  = 2'(REQ);
    localparam logic [1:0]  ST_HOLD = 2'(HOLD);

    logic [1:0]        state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [ADDR_W-1:0] redir_pc, redir_d;
    logic              drop_pend, drop_d;
    logic [INST_W-1:0] inst_d;
    logic [ADDR_W-1:0] inst_pc_d;
    logic [CNT_W-1:0]  count_d;
    logic              mem_req_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic              inst_valid_d;
    logic [ADDR_W-1:0] tgt;

    assign tgt = bus.br_target & ~ADDR_W'(INST_BYTES - 1);

    // Next-state and next-output logic; a branch always beats a capture or an accept.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        redir_d   = redir_pc;
        drop_d    = drop_pend;
        inst_d    = bus.inst;
        inst_pc_d = bus.inst_pc;
        count_d   = fetch_count;

        case (state)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (bus.br_taken) pc_d = tgt;
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    drop_d = 1'b0;
                    if (bus.br_taken) begin
                        pc_d = tgt;
                    end else if (drop_pend) begin
                        pc_d = redir_pc;
                    end else begin
                        inst_d    = bus.mem_rdata;
                        inst_pc_d = pc;
                        state_d   = ST_HOLD;
                    end
                end else if (bus.br_taken) begin
                    // Request already on the bus: let it finish, discard later.
                    drop_d  = 1'b1;
                    redir_d = tgt;
                end
            end
            ST_HOLD: begin
                if (bus.br_taken) begin
                    pc_d    = tgt;
                    state_d = ST_REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = pc + ADDR_W'(INST_BYTES);
                    count_d = fetch_count + CNT_W'(1);
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        mem_req_d    = (state_d == ST_REQ);
        mem_addr_d   = (state_d == ST_REQ) ? pc_d : bus.mem_addr;
        inst_valid_d = (state_d == ST_HOLD);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= ST_IDLE;
            pc             <= RESET_PC;
            redir_pc       <= RESET_PC;
            drop_pend      <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= RESET_PC;
            bus.inst_valid <= 1'b0;
            bus.inst       <= '0;
            bus.inst_pc    <= RESET_PC;
            fetch_count    <= '0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            redir_pc       <= redir_d;
            drop_pend      <= drop_d;
            bus.mem_req    <= mem_req_d;
            bus.mem_addr   <= mem_addr_d;
            bus.inst_valid <= inst_valid_d;
            bus.inst       <= inst_d;
            bus.inst_pc    <= inst_pc_d;
            fetch_count    <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

    logic       clk;
    logic       nreset;
    logic [7:0] fetch_count;
    int         tests;
    int         fails;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus),
        .fetch_count (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Code-memory contents as a pure function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_0001;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #12;
        tests++;
        if ({bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, fetch_count} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h0}) begin
            fails++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b inst=%h ipc=%h cnt=%0d, want all reset",
                     bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, fetch_count);
        end
        tick();
        tick();
        tests++;
        if ({bus.mem_req, bus.inst_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_held: got req=%b v=%b want 0 0", bus.mem_req, bus.inst_valid);
        end
        @(negedge clk) nreset = 1'b1;
        tick();
        tests++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL first_req: got req=%b addr=%h want 1 00000000", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_zero_wait();
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(bus.mem_addr);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
        tests++;
        if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req} !== {1'b1, 32'hE3A0_0001, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL zero_wait_present: got v=%b inst=%h ipc=%h req=%b want 1 e3a00001 00000000 0",
                     bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++;
        if ({bus.mem_req, bus.mem_addr, bus.inst_valid, fetch_count} !== {1'b1, 32'h4, 1'b0, 8'd1}) begin
            fails++;
            $display("FAIL zero_wait_next: got req=%b addr=%h v=%b cnt=%0d want 1 00000004 0 1",
                     bus.mem_req, bus.mem_addr, bus.inst_valid, fetch_count);
        end
    endtask

    task automatic test_stall();
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(bus.mem_addr);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req, fetch_count} !==
                {1'b1, memf(32'h4), 32'h4, 1'b0, 8'd1}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b inst=%h ipc=%h req=%b cnt=%0d want 1 %h 00000004 0 1",
                         i, bus.inst_valid, bus.inst, bus.inst_pc, bus.mem_req, fetch_count, memf(32'h4));
            end
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++;
        if ({bus.mem_req, bus.mem_addr, fetch_count} !== {1'b1, 32'h8, 8'd2}) begin
            fails++;
            $display("FAIL stall_release: got req=%b addr=%h cnt=%0d want 1 00000008 2",
                     bus.mem_req, bus.mem_addr, fetch_count);
        end
    endtask

    task automatic test_branch_hold();
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(bus.mem_addr);
        tick();
        bus.mem_ack = 1'b0;
        bus.br_taken = 1'b1; bus.br_target = 32'h0000_0103; bus.inst_ready = 1'b1;
        tick();
        bus.br_taken = 1'b0; bus.inst_ready = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.mem_req, bus.mem_addr, fetch_count} !== {1'b0, 1'b1, 32'h100, 8'd2}) begin
            fails++;
            $display("FAIL branch_hold: got v=%b req=%b addr=%h cnt=%0d want 0 1 00000100 2",
                     bus.inst_valid, bus.mem_req, bus.mem_addr, fetch_count);
        end
    endtask

    task automatic test_branch_req();
        bus.br_taken = 1'b1; bus.br_target = 32'h40;
        tick();
        bus.br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h100}) begin
                fails++;
                $display("FAIL branch_req_addr_hold[%0d]: got req=%b addr=%h want 1 00000100",
                         i, bus.mem_req, bus.mem_addr);
            end
            tick();
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h100);
        tick();
        bus.mem_ack = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            fails++;
            $display("FAIL branch_req_drop: got v=%b req=%b addr=%h want 0 1 00000040",
                     bus.inst_valid, bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h40);
        tick();
        bus.mem_ack = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.inst, bus.inst_pc} !== {1'b1, memf(32'h40), 32'h40}) begin
            fails++;
            $display("FAIL branch_req_target: got v=%b inst=%h ipc=%h want 1 %h 00000040",
                     bus.inst_valid, bus.inst, bus.inst_pc, memf(32'h40));
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        // Two branches during one wait: the later one wins.
        tick();
        bus.br_taken = 1'b1; bus.br_target = 32'h40;
        tick();
        bus.br_target = 32'h80;
        tick();
        bus.br_taken = 1'b0;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h44);
        tick();
        bus.mem_ack = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h80}) begin
            fails++;
            $display("FAIL branch_req_later_wins: got v=%b req=%b addr=%h want 0 1 00000080",
                     bus.inst_valid, bus.mem_req, bus.mem_addr);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h80);
        tick();
        bus.mem_ack = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++;
        if ({bus.mem_addr, fetch_count} !== {32'h84, 8'd4}) begin
            fails++;
            $display("FAIL branch_req_accept: got addr=%h cnt=%0d want 00000084 4", bus.mem_addr, fetch_count);
        end
        bus.br_taken = 1'b1; bus.br_target = 32'h200; bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h84);
        tick();
        bus.br_taken = 1'b0; bus.mem_ack = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h200}) begin
            fails++;
            $display("FAIL branch_with_ack: got v=%b req=%b addr=%h want 0 1 00000200",
                     bus.inst_valid, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_wrap();
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFE;
        tick();
        bus.br_taken = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = memf(32'h200);
        tick();
        bus.mem_rdata = memf(32'hFFFF_FFFC);
        tick();
        bus.mem_ack = 1'b0;
        tests++;
        if ({bus.inst_valid, bus.inst_pc, bus.inst} !== {1'b1, 32'hFFFF_FFFC, memf(32'hFFFF_FFFC)}) begin
            fails++;
            $display("FAIL wrap_present: got v=%b ipc=%h inst=%h want 1 fffffffc %h",
                     bus.inst_valid, bus.inst_pc, bus.inst, memf(32'hFFFF_FFFC));
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        tests++;
        if ({bus.mem_req, bus.mem_addr, fetch_count} !== {1'b1, 32'h0, 8'd5}) begin
            fails++;
            $display("FAIL wrap_pc: got req=%b addr=%h cnt=%0d want 1 00000000 5",
                     bus.mem_req, bus.mem_addr, fetch_count);
        end
    endtask

    task automatic test_count_wrap();
        logic [7:0] exp_cnt;
        exp_cnt = 8'd5;
        for (int i = 0; i < 256; i++) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = memf(bus.mem_addr);
            tick();
            bus.mem_ack = 1'b0;
            bus.inst_ready = 1'b1;
            tick();
            bus.inst_ready = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
            tests++;
            if (fetch_count !== exp_cnt) begin
                fails++;
                $display("FAIL count_step[%0d]: got cnt=%0d want %0d", i, fetch_count, exp_cnt);
            end
            if (i == 250) begin
                tests++;
                if (fetch_count !== 8'd0) begin
                    fails++;
                    $display("FAIL count_wrap_zero: got cnt=%0d want 0", fetch_count);
                end
            end
        end
        tests++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h400}) begin
            fails++;
            $display("FAIL count_wrap_addr: got req=%b addr=%h want 1 00000400", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2 nreset = 1'b0;
        #1;
        tests++;
        if ({bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, fetch_count} !==
            {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 8'h0}) begin
            fails++;
            $display("FAIL async_reset: got req=%b addr=%h v=%b inst=%h ipc=%h cnt=%0d want all reset",
                     bus.mem_req, bus.mem_addr, bus.inst_valid, bus.inst, bus.inst_pc, fetch_count);
        end
        @(negedge clk) nreset = 1'b1;
        tick();
        tests++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL async_restart: got req=%b addr=%h want 1 00000000", bus.mem_req, bus.mem_addr);
        end
        nreset = 1'b0;
        #2;
        @(negedge clk) begin
            nreset = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h55;
        end
        tick();
        bus.br_taken = 1'b0;
        tests++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h54}) begin
            fails++;
            $display("FAIL branch_idle: got req=%b addr=%h want 1 00000054", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [7:0]  exp_cnt;
        logic        prev_pend;
        logic [31:0] prev_addr;
        int          wcnt;
        int          presented;
        nreset = 1'b0;
        #3;
        @(negedge clk) nreset = 1'b1;
        tick();
        exp_pc = 32'h0; exp_cnt = 8'd0; prev_pend = 1'b0; prev_addr = 32'h0;
        wcnt = -1; presented = 0;
        for (int c = 0; c < 4000; c++) begin
            tests++;
            if (fetch_count !== exp_cnt) begin
                fails++;
                $display("FAIL rand_count[%0d]: got %0d want %0d", c, fetch_count, exp_cnt);
            end
            if (bus.inst_valid) begin
                presented++;
                tests++;
                if ({bus.inst_pc, bus.inst} !== {exp_pc, memf(exp_pc)}) begin
                    fails++;
                    $display("FAIL rand_inst[%0d]: got ipc=%h inst=%h want %h %h",
                             c, bus.inst_pc, bus.inst, exp_pc, memf(exp_pc));
                end
            end
            tests++;
            if (bus.mem_req && bus.inst_valid) begin
                fails++;
                $display("FAIL rand_req_in_hold[%0d]: got req=1 v=1 want not both", c);
            end
            if (prev_pend) begin
                tests++;
                if ({bus.mem_req, bus.mem_addr} !== {1'b1, prev_addr}) begin
                    fails++;
                    $display("FAIL rand_addr_stable[%0d]: got req=%b addr=%h want 1 %h",
                             c, bus.mem_req, bus.mem_addr, prev_addr);
                end
            end
            if (bus.mem_req) begin
                if (wcnt < 0) wcnt = int'($urandom_range(0, 3));
                bus.mem_ack = (wcnt == 0);
                if (wcnt == 0) wcnt = -1;
                else wcnt--;
            end else begin
                bus.mem_ack = 1'b0;
            end
            bus.mem_rdata  = bus.mem_ack ? memf(bus.mem_addr) : $urandom;
            bus.inst_ready = 1'($urandom % 2);
            bus.br_taken   = (($urandom % 12) == 0);
            bus.br_target  = $urandom;
            prev_pend = bus.mem_req && !bus.mem_ack;
            prev_addr = bus.mem_addr;
            if (bus.br_taken) begin
                exp_pc = bus.br_target & ~32'h3;
            end else if (bus.inst_valid && bus.inst_ready) begin
                exp_pc  = exp_pc + 32'h4;
                exp_cnt = exp_cnt + 8'd1;
            end
            tick();
        end
        bus.mem_ack = 1'b0; bus.inst_ready = 1'b0; bus.br_taken = 1'b0;
        tests++;
        if (presented < 100) begin
            fails++;
            $display("FAIL rand_progress: got %0d presented cycles want >= 100", presented);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        nreset = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.inst_ready = 1'b0;
        bus.br_taken = 1'b0; bus.br_target = '0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_branch_hold();
        test_branch_req();
        test_wrap();
        test_count_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
